// File: rtl/shared_pkg.sv
// rtl/shared_pkg.sv - shared UART parameters and TX feeder state type
package shared_pkg;

  // Byte width shared by the UART TX path
  localparam int DATA_WIDTH = 8;

  // Default depth of the TX feeder buffer (power of two, >= 2)
  localparam int TXF_DEPTH = 8;

  // TX feeder launch sequencer states
  typedef enum logic [1:0] {
    TXF_IDLE  = 2'd0,
    TXF_START = 2'd1,
    TXF_WAIT  = 2'd2
  } txf_state_e;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO with level counter, full/empty and guarded push/pop
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [LVL_W-1:0] level,
  output logic             full,
  output logic             empty
);

  // DEPTH is a power of two, so the pointers wrap naturally at DEPTH
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             push_ok;
  logic             pop_ok;

  // Flags come straight from the level register so they can never disagree
  assign full      = (level_q == LVL_MAX);
  assign empty     = (level_q == '0);
  assign level     = level_q;
  assign head_data = mem_q[rd_ptr_q];

  // A push into a full FIFO and a pop from an empty one are both ignored
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Next pointer and level values; push+pop together leaves level unchanged
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // Pointer and level registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage array; contents are only meaningful below the level, so no reset
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// rtl/uart_tx_feeder.sv - buffers APB-written bytes and launches them one at a time into the UART TX
module uart_tx_feeder #(
  parameter int DATA_WIDTH = shared_pkg::DATA_WIDTH,
  parameter int FIFO_DEPTH = shared_pkg::TXF_DEPTH,
  parameter int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  ovf_clr,
  input  logic                  tx_done,
  output logic                  tx_start,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  full,
  output logic                  empty,
  output logic [LVL_W-1:0]      level,
  output logic                  busy,
  output logic                  overflow
);

  import shared_pkg::*;

  txf_state_e            state_q;
  logic                  tx_start_q;
  logic [DATA_WIDTH-1:0] tx_data_q;
  logic                  busy_q;
  logic                  overflow_q, overflow_d;

  logic [DATA_WIDTH-1:0] fifo_head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_pop;
  logic                  wr_drop;

  // The head byte is consumed exactly on the edge the sequencer leaves IDLE
  assign fifo_pop = (state_q == TXF_IDLE) && !fifo_empty;

  // Full is judged on the registered level, so a same-cycle pop cannot rescue a write
  assign wr_drop = wr_en && fifo_full;

  sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (wr_en),
    .push_data (wr_data),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .level     (level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Launch sequencer: pop and pulse tx_start, then hold tx_data until the frame completes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= TXF_IDLE;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      case (state_q)
        TXF_IDLE: begin
          if (!fifo_empty) begin
            tx_data_q  <= fifo_head;
            tx_start_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= TXF_START;
          end
        end
        TXF_START: begin
          state_q <= TXF_WAIT;
        end
        TXF_WAIT: begin
          if (tx_done) begin
            busy_q  <= 1'b0;
            state_q <= TXF_IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= TXF_IDLE;
        end
      endcase
    end
  end

  // Sticky overflow: a dropped write outranks a clear in the same cycle
  always_comb begin
    overflow_d = overflow_q;
    if (wr_drop) begin
      overflow_d = 1'b1;
    end else if (ovf_clr) begin
      overflow_d = 1'b0;
    end
  end

  // Overflow flag register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign busy     = busy_q;
  assign overflow = overflow_q;
  assign full     = fifo_full;
  assign empty    = fifo_empty;

endmodule
